uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Parametrised UART receiver; next generation of the team's fixed 8N1 receiver.
- Configurable data width, runtime parity mode, start-bit glitch rejection, parity and framing error flags.
- Output buffered in a small FIFO with valid/ready handshake, replacing the init/done pulse pair.
- Sits between the pad-side rx line and a bus-side consumer (register block or DMA).

Parameters:
- DATA_WIDTH, 8, data bits per frame, legal 5..9, LSB first on the wire.
- FIFO_DEPTH, 4, received-frame buffer entries, power of two, >= 2.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- rx_i  in  1  serial line, asynchronous, idle high
- baud_div_i  in  32  bit period = baud_div_i + 1 clocks; minimum legal value 3
- parity_i  in  2  00 none, 01 odd, 10 even, 11 none
- rx_data_o  out  DATA_WIDTH  FIFO head data
- rx_perr_o  out  1  FIFO head parity error flag
- rx_ferr_o  out  1  FIFO head framing error flag
- rx_valid_o  out  1  FIFO non-empty
- rx_ready_i  in  1  consumer accepts head when high with rx_valid_o
- overrun_o  out  1  one-cycle pulse: completed frame dropped, FIFO full
- busy_o  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values:
  - outputs: rx_valid_o=0, rx_data_o=0, rx_perr_o=0, rx_ferr_o=0, overrun_o=0, busy_o=0.
  - internal: FIFO pointers 0, state IDLE, baud counter 0, synchroniser flops 1.
- rx_i passes through a 2-flop synchroniser (reset value 1); falling-edge detect on the synchronised value.
- Baud counter:
  - counts 0..baud_div_i; tick asserted for one cycle when count == baud_div_i; count wraps to 0 on tick.
  - On start-edge detect in IDLE, counter loads baud_div_i>>1, so the first tick lands mid start bit.
- State machine:
  - IDLE: on falling edge -> START; latch parity_i (mid-frame parity_i changes are ignored).
  - START: at tick, sampled line 1 -> IDLE (glitch, no FIFO write); sampled 0 -> DATA, bit index 0.
  - DATA: at each tick, shift sample into MSB of shift register (LSB-first assembly). After DATA_WIDTH samples -> PARITY if mode 01/10, else STOP.
  - PARITY: at tick, perr = (XOR of data bits ^ sample) != expected; expected is 1 for odd, 0 for even. -> STOP.
  - STOP: at tick, ferr = !sample; request FIFO write; -> IDLE in the same cycle.
  - Only one stop bit is checked. A new start edge is accepted from the cycle after STOP exit, including during a second stop bit.
- Latency: FIFO write on the clock edge after the STOP tick; rx_valid_o high one cycle after that write.
- FIFO:
  - entry = {perr, ferr, data}; first-word fall-through, so head outputs are valid whenever rx_valid_o=1.
  - Pop when rx_valid_o & rx_ready_i.
  - Push and pop in the same cycle is legal even when full; the frame is then accepted with no overrun.
  - Write when full without a simultaneous pop: frame dropped, overrun_o pulses 1 cycle, existing entries untouched.
  - rx_data_o holds its last value when empty.
- baud_div_i must be stable while busy_o=1; otherwise behaviour is undefined but must not lock up (next IDLE recovers).
- Reset asserted mid-frame: all state cleared immediately; FIFO contents discarded.

Optional Feature:
- Macro UART_RX_FRAME_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of synchronised samples taken at tick-1, tick and tick+1; the decision applies at tick+1. Start-glitch check, parity and stop checks use the voted value. Latency grows by 1 cycle; requires baud_div_i >= 4.
- Undefined: single sample at tick, as above.

Test Plan:
- baud_div_i=15, parity 00, DATA_WIDTH=8, send 0x55 8N1, rx_ready_i=1 -> one entry, data 0x55, perr=0, ferr=0; rx_valid_o high for 1 cycle.
- parity 10 (even), send 0xA3 with parity bit 1 (wrong) -> data 0xA3, perr=1, ferr=0; repeat with parity bit 0 -> perr=0.
- Send 0x0F with stop bit driven 0 -> data 0x0F, ferr=1; next correctly framed 0x12 received with ferr=0.
- Drive rx_i low for 5 clocks (baud_div_i=15) then high -> no FIFO write, busy_o returns 0 after the mid-start tick.
- rx_ready_i=0, send 5 frames 0x01..0x05, FIFO_DEPTH=4 -> overrun_o one pulse at frame 5; drain yields 0x01..0x04 only.
- Assert rst_n_i low mid DATA of frame 0x3C, release, send 0x7E -> only 0x7E received, no errors.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with runtime parity, start-glitch
// rejection, parity/framing flags and a first-word-fall-through output FIFO.
// Optional build macro UART_RX_FRAME_MAJORITY_EN: 2-of-3 majority vote of the
// samples at tick-1, tick and tick+1 (decision one cycle later, baud_div_i >= 4).
module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rx_i,
  input  logic [31:0]           baud_div_i,
  input  logic [1:0]            parity_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_perr_o,
  output logic                  rx_ferr_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = DATA_WIDTH + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t state_q, state_d;

  logic [1:0]            sync_q;
  logic                  rx_prev_q;
  logic                  rx_s_c, fall_c, tick_c, samp_en_c, samp_bit_c;
  logic [31:0]           cnt_q;
  logic [1:0]            par_mode_q;
  logic                  par_on_c;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  perr_q;
  logic                  wr_req_q;
  logic [ENT_W-1:0]      wr_entry_q;
  logic                  start_c, shift_c, par_c, stop_c;

  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  logic [PTR_W:0]        count_q, count_nx;
  logic                  push_c, pop_c, full_c, ovr_c;
  logic [ENT_W-1:0]      head_nx;

  assign rx_s_c   = sync_q[1];
  assign fall_c   = rx_prev_q & ~rx_s_c;
  assign par_on_c = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
  // Compare with >= so a baud_div_i lowered mid-frame cannot strand the counter.
  assign tick_c   = (cnt_q >= baud_div_i);

  // Two-flop synchroniser plus previous value for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= sync_q[1];
    end
  end

`ifdef UART_RX_FRAME_MAJORITY_EN
  logic [1:0] hist_q;
  logic       tick_q;

  // Keep the two previous samples and delay the tick so the vote sees tick+1.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist_q <= 2'b11;
      tick_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], rx_s_c};
      tick_q <= tick_c & (state_q != S_IDLE);
    end
  end

  assign samp_en_c  = tick_q;
  assign samp_bit_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_c) | (hist_q[0] & rx_s_c);
`else
  assign samp_en_c  = tick_c & (state_q != S_IDLE);
  assign samp_bit_c = rx_s_c;
`endif

  // Baud counter; a start edge preloads half a period so ticks land mid-bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 32'd0;
    end else if (state_q == S_IDLE && fall_c) begin
      cnt_q <= baud_div_i >> 1;
    end else if (tick_c) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    shift_c = 1'b0;
    par_c   = 1'b0;
    stop_c  = 1'b0;
    case (state_q)
      S_IDLE: if (fall_c) begin
        state_d = S_START;
        start_c = 1'b1;
      end
      S_START: if (samp_en_c) state_d = samp_bit_c ? S_IDLE : S_DATA;
      S_DATA: if (samp_en_c) begin
        shift_c = 1'b1;
        if (bit_idx_q == LAST_IDX) state_d = par_on_c ? S_PARITY : S_STOP;
      end
      S_PARITY: if (samp_en_c) begin
        par_c   = 1'b1;
        state_d = S_STOP;
      end
      S_STOP: if (samp_en_c) begin
        stop_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame assembly: LSB-first shift, parity check, FIFO write request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      par_mode_q <= 2'b00;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_entry_q <= '0;
      busy_o     <= 1'b0;
    end else begin
      busy_o   <= (state_d != S_IDLE);
      wr_req_q <= stop_c;
      if (start_c) begin
        par_mode_q <= parity_i;
        perr_q     <= 1'b0;
        bit_idx_q  <= '0;
      end
      if (shift_c) begin
        shreg_q   <= {samp_bit_c, shreg_q[DATA_WIDTH-1:1]};
        bit_idx_q <= bit_idx_q + 1'b1;
      end
      if (par_c) perr_q <= ((^shreg_q) ^ samp_bit_c) != (par_mode_q == 2'b01);
      if (stop_c) wr_entry_q <= {perr_q, ~samp_bit_c, shreg_q};
    end
  end

  assign pop_c  = rx_valid_o & rx_ready_i;
  assign full_c = (count_q == FULL_CNT);
  assign push_c = wr_req_q & (~full_c | pop_c);
  assign ovr_c  = wr_req_q & full_c & ~pop_c;

  // Next FIFO occupancy/read pointer and the entry that becomes the head.
  always_comb begin
    count_nx = count_q;
    if (push_c && !pop_c)      count_nx = count_q + 1'b1;
    else if (!push_c && pop_c) count_nx = count_q - 1'b1;
    rd_ptr_nx = pop_c ? rd_ptr_q + 1'b1 : rd_ptr_q;
    head_nx   = (push_c && (rd_ptr_nx == wr_ptr_q)) ? wr_entry_q : mem_q[rd_ptr_nx];
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_entry_q;
  end

  // FIFO pointers and registered head/valid/overrun outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_perr_o  <= 1'b0;
      rx_ferr_o  <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q   <= rd_ptr_nx;
      count_q    <= count_nx;
      rx_valid_o <= (count_nx != '0);
      overrun_o  <= ovr_c;
      if (count_nx != '0) {rx_perr_o, rx_ferr_o, rx_data_o} <= head_nx;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: a scoreboard queue holds expected
// {perr, ferr, data} entries; a monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int unsigned DW  = 8;
  localparam int          DIV = 15;
  localparam int          BIT = DIV + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [31:0]   baud_div;
  logic [1:0]    parity;
  logic [DW-1:0] rx_data;
  logic          rx_perr, rx_ferr, rx_valid, ready, overrun, busy;

  logic [DW+1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            ovr_cnt = 0;
  int            valid_cycles = 0;

  uart_rx_frame #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rx_i       (rx),
    .baud_div_i (baud_div),
    .parity_i   (parity),
    .rx_data_o  (rx_data),
    .rx_perr_o  (rx_perr),
    .rx_ferr_o  (rx_ferr),
    .rx_valid_o (rx_valid),
    .rx_ready_i (ready),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clk) begin
    logic [DW+1:0] exp_e;
    if (rst_n && rx_valid && ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_frame: got perr=%b ferr=%b data=%h, none expected",
                 rx_perr, rx_ferr, rx_data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({rx_perr, rx_ferr, rx_data} !== exp_e) begin
          n_bad++;
          $display("FAIL frame: got perr=%b ferr=%b data=%h, want perr=%b ferr=%b data=%h",
                   rx_perr, rx_ferr, rx_data, exp_e[DW+1], exp_e[DW], exp_e[DW-1:0]);
        end
      end
    end
    if (rst_n && overrun) ovr_cnt++;
    if (rst_n && rx_valid) valid_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit has_par, input bit pbit,
                            input bit stop, input int idle_bits);
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pbit);
    drive_bit(stop);
    for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1; ready = 1'b1; baud_div = 32'(DIV); parity = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rx_data !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h want 00", rx_data);
    end
    n_cmp++;
    if ({rx_valid, rx_perr, rx_ferr, overrun, busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got valid/perr/ferr/ovr/busy=%b want 00000",
               {rx_valid, rx_perr, rx_ferr, overrun, busy});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    parity = 2'b00; ready = 1'b1; valid_cycles = 0;
    exp_q.push_back({1'b0, 1'b0, 8'h55});
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1);
    wait_drain(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_drain: got %0d pending want 0", exp_q.size()); end
    n_cmp++;
    if (valid_cycles != 1) begin
      n_bad++; $display("FAIL basic_valid_width: got %0d cycles want 1", valid_cycles);
    end
  endtask

  task automatic test_parity;
    bit ok;
    ready = 1'b1;
    parity = 2'b10;
    exp_q.push_back({1'b1, 1'b0, 8'hA3}); send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1);
    exp_q.push_back({1'b0, 1'b0, 8'hA3}); send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1);
    parity = 2'b01;
    exp_q.push_back({1'b0, 1'b0, 8'hA3}); send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1);
    exp_q.push_back({1'b1, 1'b0, 8'hA3}); send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1);
    parity = 2'b11;
    exp_q.push_back({1'b0, 1'b0, 8'h3C}); send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1);
    // parity_i drops to none mid-frame; the latched even mode must still apply
    parity = 2'b10;
    exp_q.push_back({1'b1, 1'b0, 8'h81});
    fork
      send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1);
      begin repeat (BIT * 3) @(posedge clk); #1 parity = 2'b00; end
    join
    wait_drain(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL parity_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_framing;
    bit ok;
    parity = 2'b00; ready = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h0F}); send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1);
    exp_q.push_back({1'b0, 1'b0, 8'h12}); send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1);
    wait_drain(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL framing_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_glitch;
    bit ok;
    parity = 2'b00; ready = 1'b1;
    @(posedge clk); #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    repeat (30) @(negedge clk);
    n_cmp++;
    if ({busy, rx_valid} !== 2'b00) begin
      n_bad++; $display("FAIL glitch_reject: got busy/valid=%b want 00", {busy, rx_valid});
    end
    exp_q.push_back({1'b0, 1'b0, 8'hA5}); send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1);
    wait_drain(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL glitch_after_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_overrun;
    bit ok;
    parity = 2'b00;
    @(posedge clk); #1 ready = 1'b0;
    ovr_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({2'b00, 8'(i)});
      send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1);
    end
    @(negedge clk);
    n_cmp++;
    if (ovr_cnt != 0) begin n_bad++; $display("FAIL overrun_early: got %0d pulses want 0", ovr_cnt); end
    n_cmp++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h01}) begin
      n_bad++; $display("FAIL overrun_head: got valid=%b data=%h want 1/01", rx_valid, rx_data);
    end
    send_frame(8'h05, 1'b0, 1'b0, 1'b1, 1);
    @(negedge clk);
    n_cmp++;
    if (ovr_cnt != 1) begin n_bad++; $display("FAIL overrun_pulse: got %0d pulses want 1", ovr_cnt); end
    @(posedge clk); #1 ready = 1'b1;
    wait_drain(50, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL overrun_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    parity = 2'b00; ready = 1'b1;
    @(posedge clk); #1;
    drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
    repeat (BIT / 2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
    #1 rst_n = 1'b0; rx = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, rx_valid} !== 2'b00) begin
      n_bad++; $display("FAIL midreset_cleared: got busy/valid=%b want 00", {busy, rx_valid});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (BIT) @(posedge clk);
    exp_q.push_back({1'b0, 1'b0, 8'h7E}); send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1);
    wait_drain(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midreset_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [DW-1:0] d;
    logic p;
    parity = 2'b10; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      exp_q.push_back({((^d) ^ p), 1'b0, d});
      send_frame(d, 1'b1, p, 1'b1, 0);
    end
    drive_bit(1'b1);
    wait_drain(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
